// File: rtl/control_types.sv
// Shared pipeline control types: memory access size encodings and MEM-stage FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package control_types;

   // funct3 encoding of load/store width; 011, 110 and 111 are illegal.
   typedef enum logic [2:0] {
      MEMSZ_B  = 3'b000,
      MEMSZ_H  = 3'b001,
      MEMSZ_W  = 3'b010,
      MEMSZ_BU = 3'b100,
      MEMSZ_HU = 3'b101
   } mem_size_t;

   typedef enum logic [1:0] {
      MEMFSM_IDLE = 2'd0,
      MEMFSM_BUSY = 2'd1,
      MEMFSM_DONE = 2'd2
   } mem_fsm_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, lane extraction plus sign/zero extension for loads, alignment check.
// Latency: purely combinational.
// Backpressure: none.
// Ports: size (funct3), offset (addr[1:0]), store_data/load_word in; byte_en, store_lanes,
//        load_data and access_ok (legal size and naturally aligned) out.
module mem_lane_align
   import control_types::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_lanes,
   output logic [31:0] load_data,
   output logic        access_ok
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte = load_word[7:0];
      case (offset)
         2'd0:    sel_byte = load_word[7:0];
         2'd1:    sel_byte = load_word[15:8];
         2'd2:    sel_byte = load_word[23:16];
         default: sel_byte = load_word[31:24];
      endcase
      // Halfwords are only ever taken from an even offset; offset[0] is rejected below.
      sel_half = offset[1] ? load_word[31:16] : load_word[15:0];
   end

   always_comb begin
      byte_en     = 4'b0000;
      store_lanes = 32'h0;
      load_data   = 32'h0;
      access_ok   = 1'b0;
      case (mem_size_t'(size))
         MEMSZ_B, MEMSZ_BU: begin
            access_ok   = 1'b1;
            byte_en     = 4'b0001 << offset;
            // Replicated on every lane so the byte enables alone pick the target byte.
            store_lanes = {4{store_data[7:0]}};
            load_data   = (mem_size_t'(size) == MEMSZ_B) ? {{24{sel_byte[7]}}, sel_byte}
                                                          : {24'h0, sel_byte};
         end
         MEMSZ_H, MEMSZ_HU: begin
            access_ok   = ~offset[0];
            byte_en     = 4'b0011 << offset;
            store_lanes = {2{store_data[15:0]}};
            load_data   = (mem_size_t'(size) == MEMSZ_H) ? {{16{sel_half[15]}}, sel_half}
                                                          : {16'h0, sel_half};
         end
         MEMSZ_W: begin
            access_ok   = (offset == 2'b00);
            byte_en     = 4'b1111;
            store_lanes = store_data;
            load_data   = load_word;
         end
         default: begin
            access_ok = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns load/store control into word-aligned bus transactions.
// Latency: 2 stall cycles minimum (ack in first BUSY cycle); 1 stall cycle for an illegal access.
// Backpressure: mem_stall holds the upstream pipeline until bus_ack or TIMEOUT_CYCLES BUSY cycles.
// Ports: pipeline control/address/store data in; mem_data_out_mem, mem_stall, mem_fault out;
//        bus_req/bus_we/bus_addr/bus_be/bus_wdata out and bus_ack/bus_rdata in.
module mem_access_unit
   import control_types::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_mem,
   input  logic        mem_read_ctrl_mem,
   input  logic        mem_write_ctrl_mem,
   input  logic [2:0]  mem_size_ctrl_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] mem_wr_data_mem,
   input  logic        flush,
   output logic [31:0] mem_data_out_mem,
   output logic        mem_stall,
   output logic        mem_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   mem_fsm_t      state;
   logic [CW-1:0] cnt;
   logic          abort;

   logic          req;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata;
   logic [31:0]   lane_load;
   logic          access_ok;

   assign req       = valid_mem & (mem_read_ctrl_mem | mem_write_ctrl_mem) & ~flush;
   // DONE is the single cycle the pipeline is released so MEM/WB captures the result.
   assign mem_stall = req & (state != MEMFSM_DONE);

   // Inputs are held stable by the stall, so the live address/size also format the read data.
   mem_lane_align u_lane_align (
      .size        (mem_size_ctrl_mem),
      .offset      (alu_result_mem[1:0]),
      .store_data  (mem_wr_data_mem),
      .load_word   (bus_rdata),
      .byte_en     (lane_be),
      .store_lanes (lane_wdata),
      .load_data   (lane_load),
      .access_ok   (access_ok)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= MEMFSM_IDLE;
         cnt              <= '0;
         abort            <= 1'b0;
         bus_req          <= 1'b0;
         bus_we           <= 1'b0;
         bus_addr         <= 32'h0;
         bus_be           <= 4'b0000;
         bus_wdata        <= 32'h0;
         mem_data_out_mem <= 32'h0;
         mem_fault        <= 1'b0;
      end else begin
         case (state)
            MEMFSM_IDLE: begin
               if (req) begin
                  if (access_ok) begin
                     bus_req   <= 1'b1;
                     bus_we    <= mem_write_ctrl_mem;
                     bus_addr  <= {alu_result_mem[31:2], 2'b00};
                     bus_be    <= lane_be;
                     bus_wdata <= lane_wdata;
                     cnt       <= '0;
                     state     <= MEMFSM_BUSY;
                  end else begin
                     mem_fault        <= 1'b1;
                     mem_data_out_mem <= 32'h0;
                     state            <= MEMFSM_DONE;
                  end
               end
            end

            MEMFSM_BUSY: begin
               cnt <= cnt + 1'b1;
               if (flush) begin
                  abort <= 1'b1;
               end
               // The bus transaction always runs to ack or timeout; an abort only
               // suppresses the result and skips the DONE release cycle.
               if (bus_ack || (cnt == CNT_LAST)) begin
                  bus_req <= 1'b0;
                  if (abort || flush) begin
                     state <= MEMFSM_IDLE;
                     cnt   <= '0;
                     abort <= 1'b0;
                  end else begin
                     state            <= MEMFSM_DONE;
                     mem_fault        <= ~bus_ack;
                     mem_data_out_mem <= (bus_ack && !bus_we) ? lane_load : 32'h0;
                  end
               end
            end

            MEMFSM_DONE: begin
               state <= MEMFSM_IDLE;
               cnt   <= '0;
               abort <= 1'b0;
            end

            default: begin
               state <= MEMFSM_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected results, monitors compare.
// Latency: n/a.
// Backpressure: follows mem_stall like the real pipeline would.
module tb_mem_access_unit;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_X  = 3'b011;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_mem = 1'b0;
   logic        mem_read_ctrl_mem = 1'b0;
   logic        mem_write_ctrl_mem = 1'b0;
   logic [2:0]  mem_size_ctrl_mem = 3'b000;
   logic [31:0] alu_result_mem = 32'h0;
   logic [31:0] mem_wr_data_mem = 32'h0;
   logic        flush = 1'b0;
   logic [31:0] mem_data_out_mem;
   logic        mem_stall;
   logic        mem_fault;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .valid_mem          (valid_mem),
      .mem_read_ctrl_mem  (mem_read_ctrl_mem),
      .mem_write_ctrl_mem (mem_write_ctrl_mem),
      .mem_size_ctrl_mem  (mem_size_ctrl_mem),
      .alu_result_mem     (alu_result_mem),
      .mem_wr_data_mem    (mem_wr_data_mem),
      .flush              (flush),
      .mem_data_out_mem   (mem_data_out_mem),
      .mem_stall          (mem_stall),
      .mem_fault          (mem_fault),
      .bus_req            (bus_req),
      .bus_we             (bus_we),
      .bus_addr           (bus_addr),
      .bus_be             (bus_be),
      .bus_wdata          (bus_wdata),
      .bus_ack            (bus_ack),
      .bus_rdata          (bus_rdata)
   );

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          stalls;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          cycles;
   } bus_t;

   rsp_t rsp_q[$];
   bus_t bus_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic tb_req;
   assign tb_req = valid_mem & (mem_read_ctrl_mem | mem_write_ctrl_mem) & ~flush;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Result monitor: a cycle with a live request and no stall is the DONE release cycle.
   int   stall_run = 0;
   rsp_t exp_rsp;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_run = 0;
      end else if (tb_req && mem_stall) begin
         stall_run++;
      end else if (tb_req) begin
         if (rsp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: data 0x%08h fault %0b, none expected", mem_data_out_mem, mem_fault);
         end else begin
            exp_rsp = rsp_q.pop_front();
            check("load_data", mem_data_out_mem, exp_rsp.data);
            check("mem_fault", {31'h0, mem_fault}, {31'h0, exp_rsp.fault});
            check("stall_cycles", 32'(stall_run), 32'(exp_rsp.stalls));
         end
         stall_run = 0;
      end else begin
         stall_run = 0;
      end
   end

   // Bus monitor: checks each request as it rises, and its length when it falls.
   logic prev_req = 1'b0;
   logic bus_tracked = 1'b0;
   int   req_run = 0;
   bus_t cur_bus;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
         req_run  = 0;
      end else begin
         if (bus_req && !prev_req) begin
            if (bus_q.size() == 0) begin
               n_vec++;
               n_err++;
               bus_tracked = 1'b0;
               $display("FAIL unexpected_bus_req: addr 0x%08h, no request expected", bus_addr);
            end else begin
               cur_bus     = bus_q.pop_front();
               bus_tracked = 1'b1;
               check("bus_addr", bus_addr, cur_bus.addr);
               check("bus_we", {31'h0, bus_we}, {31'h0, cur_bus.we});
               check("bus_be", {28'h0, bus_be}, {28'h0, cur_bus.be});
               if (cur_bus.we) check("bus_wdata", bus_wdata, cur_bus.wdata);
            end
            req_run = 1;
         end else if (bus_req) begin
            req_run++;
         end else if (prev_req && bus_tracked) begin
            check("bus_req_cycles", 32'(req_run), 32'(cur_bus.cycles));
         end
         prev_req = bus_req;
      end
   end

   // Issues one access (caller sits just after a rising edge) and follows mem_stall to completion.
   // ack_at: rising edge after which bus_ack is pulsed (1 = first BUSY cycle, 0 = never).
   task automatic access(input logic rd, input logic wr, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                         input int ack_at, input logic [31:0] e_data, input logic e_fault,
                         input int e_stalls, input logic [3:0] e_be, input logic [31:0] e_wdata,
                         input int e_cycles);
      rsp_t r;
      bus_t b;
      bit   done;
      r.data = e_data;
      r.fault = e_fault;
      r.stalls = e_stalls;
      rsp_q.push_back(r);
      if (e_cycles > 0) begin
         b.addr = {addr[31:2], 2'b00};
         b.we = wr;
         b.be = e_be;
         b.wdata = e_wdata;
         b.cycles = e_cycles;
         bus_q.push_back(b);
      end
      valid_mem = 1'b1;
      mem_read_ctrl_mem = rd;
      mem_write_ctrl_mem = wr;
      mem_size_ctrl_mem = sz;
      alu_result_mem = addr;
      mem_wr_data_mem = wd;
      done = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == ack_at) begin
            bus_ack = 1'b1;
            bus_rdata = rdat;
         end else begin
            bus_ack = 1'b0;
            bus_rdata = 32'hDEAD_BEEF;
         end
         if (!mem_stall) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL stall_timeout: addr 0x%08h still stalled after 40 cycles", addr);
      end
      @(posedge clk);
      #1;
      valid_mem = 1'b0;
      mem_read_ctrl_mem = 1'b0;
      mem_write_ctrl_mem = 1'b0;
      bus_ack = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("rst_data", mem_data_out_mem, 32'h0);
      check("rst_fault", {31'h0, mem_fault}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      //      rd wr  size   addr        wdata        rdata        ack expected     flt st be    exp wdata   cyc
      access(1, 0, SZ_W,  32'h100, 32'h0,        32'hFEEDF00D, 1, 32'hFEEDF00D, 0, 2, 4'hF, 32'h0,        1);
      access(1, 0, SZ_B,  32'h203, 32'h0,        32'h80FFFFFF, 1, 32'hFFFFFF80, 0, 2, 4'h8, 32'h0,        1);
      access(1, 0, SZ_BU, 32'h203, 32'h0,        32'h80FFFFFF, 1, 32'h00000080, 0, 2, 4'h8, 32'h0,        1);
      access(1, 0, SZ_HU, 32'h202, 32'h0,        32'h80011234, 1, 32'h00008001, 0, 2, 4'hC, 32'h0,        1);
      access(0, 1, SZ_B,  32'h101, 32'h000000AB, 32'h0,        1, 32'h0,        0, 2, 4'h2, 32'hABABABAB, 1);
      access(0, 1, SZ_H,  32'h103, 32'h00001234, 32'h0,        0, 32'h0,        1, 1, 4'h0, 32'h0,        0);
      access(0, 1, SZ_W,  32'h204, 32'h12345678, 32'h0,        3, 32'h0,        0, 4, 4'hF, 32'h12345678, 3);
      access(0, 1, SZ_H,  32'h102, 32'h0000BEEF, 32'h0,        1, 32'h0,        0, 2, 4'hC, 32'hBEEFBEEF, 1);
      access(1, 0, SZ_H,  32'h206, 32'h0,        32'h9ABC0000, 1, 32'hFFFF9ABC, 0, 2, 4'hC, 32'h0,        1);

      // Flush in the first BUSY cycle; the ack two cycles later must not produce a result.
      begin
         bus_t b;
         b.addr = 32'h300;
         b.we = 1'b0;
         b.be = 4'hF;
         b.wdata = 32'h0;
         b.cycles = 3;
         bus_q.push_back(b);
      end
      valid_mem = 1'b1;
      mem_read_ctrl_mem = 1'b1;
      mem_size_ctrl_mem = SZ_W;
      alu_result_mem = 32'h300;
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      valid_mem = 1'b0;
      mem_read_ctrl_mem = 1'b0;
      @(posedge clk);
      #1;
      bus_ack = 1'b1;
      bus_rdata = 32'h11111111;
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      check("abort_bus_req", {31'h0, bus_req}, 32'h0);
      check("abort_data_held", mem_data_out_mem, 32'hFFFF9ABC);
      check("abort_fault_held", {31'h0, mem_fault}, 32'h0);
      // Issued straight away: a normal 2-stall access proves the unit went back to IDLE.
      access(1, 0, SZ_W,  32'h104, 32'h0,        32'h0BADCAFE, 1, 32'h0BADCAFE, 0, 2, 4'hF, 32'h0,        1);

      access(1, 0, SZ_X,  32'h000, 32'h0,        32'h0,        0, 32'h0,        1, 1, 4'h0, 32'h0,        0);
      access(1, 0, SZ_W,  32'h102, 32'h0,        32'h0,        0, 32'h0,        1, 1, 4'h0, 32'h0,        0);
      access(1, 0, SZ_W,  32'h400, 32'h0,        32'h0,        0, 32'h0,        1, 5, 4'hF, 32'h0,        4);
      access(1, 0, SZ_W,  32'h108, 32'h0,        32'hCAFEBABE, 1, 32'hCAFEBABE, 0, 2, 4'hF, 32'h0,        1);

      // Asynchronous reset in the middle of a store's BUSY phase.
      valid_mem = 1'b1;
      mem_write_ctrl_mem = 1'b1;
      mem_size_ctrl_mem = SZ_W;
      alu_result_mem = 32'h20C;
      mem_wr_data_mem = 32'h55AA55AA;
      @(posedge clk);
      #1;
      valid_mem = 1'b0;
      mem_write_ctrl_mem = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_bus_req", {31'h0, bus_req}, 32'h0);
      check("arst_bus_we", {31'h0, bus_we}, 32'h0);
      check("arst_bus_addr", bus_addr, 32'h0);
      check("arst_bus_be", {28'h0, bus_be}, 32'h0);
      check("arst_bus_wdata", bus_wdata, 32'h0);
      check("arst_data", mem_data_out_mem, 32'h0);
      check("arst_fault", {31'h0, mem_fault}, 32'h0);
      check("arst_stall", {31'h0, mem_stall}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
      check("bus_queue_drained", 32'(bus_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
